rot_share_arb: RTL

- Shares one 16-bit multifunction rotator between two independent requesters.
- Uses round-robin arbitration over valid/ready request channels.
- The result for each accepted request is registered into a single-entry output buffer, tagged with the requester ID, and drained over a valid/ready response channel.
- Sits between two control engines and the shared rotate datapath.

---
 rtl/rot_share_pkg.sv | 16 +
 rtl/rot_share_arb_if.sv | 43 ++++
 rtl/rot_core.sv | 36 +++
 rtl/rot_share_arb.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rot_share_pkg.sv
// Shared constants and types for the rotator-sharing arbiter.
// Imported by the rotator core and the arbiter top.
package rot_share_pkg;

   localparam logic ROT_LEFT  = 1'b1;
   localparam logic ROT_RIGHT = 1'b0;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/rot_share_arb_if.sv
// Request/response bundle between two requesters, the shared rotator arbiter and its consumer.
// slave = arbiter side, master = requester/consumer side.
interface rot_share_arb_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);

   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_num;
   logic [AMT_W-1:0] req0_amt;
   logic             req0_lr;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_num;
   logic [AMT_W-1:0] req1_amt;
   logic             req1_lr;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;

   modport slave (
      input  req0_valid, req0_num, req0_amt, req0_lr,
      output req0_ready,
      input  req1_valid, req1_num, req1_amt, req1_lr,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_num, req0_amt, req0_lr,
      input  req0_ready,
      output req1_valid, req1_num, req1_amt, req1_lr,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready
   );

endinterface

// File: rtl/rot_core.sv
// Purely combinational bidirectional rotator built from log2(WIDTH) power-of-two stages.
// lr = 1 rotates left, lr = 0 rotates right; amounts wrap modulo WIDTH.
module rot_core
   import rot_share_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic [WIDTH-1:0] num,
   input  logic [AMT_W-1:0] amt,
   input  logic             lr,
   output logic [WIDTH-1:0] out
);

   function automatic logic [WIDTH-1:0] rot_l(input logic [WIDTH-1:0] x, input int s);
      return (x << s) | (x >> (WIDTH - s));
   endfunction

   function automatic logic [WIDTH-1:0] rot_r(input logic [WIDTH-1:0] x, input int s);
      return (x >> s) | (x << (WIDTH - s));
   endfunction

   logic [WIDTH-1:0] stage;

   // Stage k applies a rotate of 2**k when amt[k] is set.
   always_comb begin
      stage = num;
      for (int k = 0; k < AMT_W; k++) begin
         if (amt[k]) begin
            stage = (lr == ROT_LEFT) ? rot_l(stage, 1 << k) : rot_r(stage, 1 << k);
         end
      end
      out = stage;
   end

endmodule

// File: rtl/rot_share_arb.sv
// Round-robin arbiter sharing one rotator between two requesters, with a single-entry
// tagged result buffer. Optional grant counters: define ROT_SHARE_ARB_STATS_EN.
module rot_share_arb
   import rot_share_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4,
   parameter int CNT_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   rot_share_arb_if.slave bus
`ifdef ROT_SHARE_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
`endif
);

   if (AMT_W != $clog2(WIDTH) || WIDTH < 2 || CNT_W < 1) begin : g_bad_param
      $error("rot_share_arb: AMT_W must be log2(WIDTH), WIDTH >= 2, CNT_W >= 1");
   end

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic             can_accept, grant, acc0, acc1, accept;
   logic [WIDTH-1:0] mux_num, rot_out;
   logic [AMT_W-1:0] mux_amt;
   logic             mux_lr;

   // Arbitration: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      can_accept = (state_q == EMPTY) || bus.rsp_ready;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = ~last_grant_q;
      end else if (bus.req1_valid) begin
         grant = REQ1;
      end else begin
         grant = REQ0;
      end
      acc0    = !rst && can_accept && (grant == REQ0) && bus.req0_valid;
      acc1    = !rst && can_accept && (grant == REQ1) && bus.req1_valid;
      accept  = acc0 || acc1;
      mux_num = (grant == REQ1) ? bus.req1_num : bus.req0_num;
      mux_amt = (grant == REQ1) ? bus.req1_amt : bus.req0_amt;
      mux_lr  = (grant == REQ1) ? bus.req1_lr  : bus.req0_lr;
   end

   assign bus.req0_ready = acc0;
   assign bus.req1_ready = acc1;

   rot_core #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_rot_core (
      .num (mux_num),
      .amt (mux_amt),
      .lr  (mux_lr),
      .out (rot_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // A same-cycle accept keeps the buffer full, so drain and refill need no bubble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (!accept && bus.rsp_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      bus.rsp_valid = (state_q == FULL);
      bus.rsp_id    = rsp_id_q;
      bus.rsp_data  = rsp_data_q;
   end

   always_comb begin
      rsp_data_d   = accept ? rot_out : rsp_data_q;
      rsp_id_d     = accept ? grant   : rsp_id_q;
      last_grant_d = accept ? grant   : last_grant_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data_q   <= '0;
         rsp_id_q     <= REQ0;
         last_grant_q <= REQ1;
      end else begin
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef ROT_SHARE_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   // Counters stick at all ones instead of wrapping.
   always_comb begin
      cnt0_d = (acc0 && cnt0_q != '1) ? cnt0_q + 1'b1 : cnt0_q;
      cnt1_d = (acc1 && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule
